// File: rtl/mult_nxn_pipe.sv
// mult_nxn_pipe: 3-stage unsigned WIDTH x WIDTH multiplier built
// from 4x4 digit products, exact or carry-free per operation.
module mult_nxn_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               out_mode,
  output logic [TAG_W-1:0]   out_tag,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   approx_cnt
);

  localparam int D  = WIDTH / 4;
  localparam int PW = 2 * WIDTH;
  localparam int NP = D * D;

  logic en;
  logic accept;

  logic             v1_q;
  logic [WIDTH-1:0] a1_q;
  logic [WIDTH-1:0] b1_q;
  logic             m1_q;
  logic [TAG_W-1:0] t1_q;

  logic             v2_q;
  logic [NP*8-1:0]  pp_d;
  logic [NP*8-1:0]  pp_q;
  logic             m2_q;
  logic [TAG_W-1:0] t2_q;

  logic             ov_q;
  logic [PW-1:0]    prod_d;
  logic [PW-1:0]    prod_q;
  logic             om_q;
  logic [TAG_W-1:0] ot_q;

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // A full output register that is not drained freezes the whole pipe.
  assign en       = !ov_q || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  assign out_valid  = ov_q;
  assign out_prod   = prod_q;
  assign out_mode   = om_q;
  assign out_tag    = ot_q;
  assign approx_cnt = cnt_q;

  // S1: capture operands, mode and tag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      m1_q <= 1'b0;
      t1_q <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      a1_q <= in_a;
      b1_q <= in_b;
      m1_q <= in_mode;
      t1_q <= in_tag;
    end
  end

  // All D*D exact 4x4 digit products, p[i][j] at slot i*D+j.
  always_comb begin
    pp_d = '0;
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        pp_d[(i*D+j)*8 +: 8] = 8'(a1_q[4*i +: 4]) * 8'(b1_q[4*j +: 4]);
      end
    end
  end

  // S2: register the digit products.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v2_q <= 1'b0;
      pp_q <= '0;
      m2_q <= 1'b0;
      t2_q <= '0;
    end else if (en) begin
      v2_q <= v1_q;
      pp_q <= pp_d;
      m2_q <= m1_q;
      t2_q <= t1_q;
    end
  end

  // Place each product at 4*(i+j); add with carries or XOR per column.
  always_comb begin
    logic [PW-1:0] placed;
    logic [PW-1:0] sum;
    logic [PW-1:0] xr;
    placed = '0;
    sum    = '0;
    xr     = '0;
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        placed = PW'(pp_q[(i*D+j)*8 +: 8]) << (4*(i+j));
        sum    = sum + placed;
        xr     = xr ^ placed;
      end
    end
    prod_d = m2_q ? xr : sum;
  end

  // S3: output register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ov_q   <= 1'b0;
      prod_q <= '0;
      om_q   <= 1'b0;
      ot_q   <= '0;
    end else if (en) begin
      ov_q   <= v2_q;
      prod_q <= prod_d;
      om_q   <= m2_q;
      ot_q   <= t2_q;
    end
  end

  // Clear wins over an approximate acceptance; count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && in_mode && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Approximate-op counter register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mult_nxn_pipe.sv
// tb_mult_nxn_pipe: directed + random checks of mult_nxn_pipe
// at WIDTH=8 and WIDTH=16/CNT_W=2 against a reference model.
module tb_mult_nxn_pipe;

  logic clk = 1'b0;
  logic rst_n;

  logic        v8, irdy8, m8, ov8, rdy8, om8, clr8;
  logic [7:0]  a8, b8;
  logic [3:0]  t8, ot8;
  logic [15:0] p8, cnt8;

  logic        v16, irdy16, m16, ov16, rdy16, om16, clr16;
  logic [15:0] a16, b16;
  logic [3:0]  t16, ot16;
  logic [31:0] p16;
  logic [1:0]  cnt16;

  int checks;
  int failures;
  int cnt8m;

  typedef struct packed {
    logic [15:0] p;
    logic        m;
    logic [3:0]  t;
  } res8_t;

  res8_t q8[$];

  always #5 clk = ~clk;

  mult_nxn_pipe #(.WIDTH(8), .TAG_W(4), .CNT_W(16)) u8 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .in_valid(v8), .in_ready(irdy8),
    .in_a(a8), .in_b(b8), .in_mode(m8), .in_tag(t8),
    .out_valid(ov8), .out_ready(rdy8),
    .out_prod(p8), .out_mode(om8), .out_tag(ot8),
    .cnt_clr(clr8), .approx_cnt(cnt8)
  );

  mult_nxn_pipe #(.WIDTH(16), .TAG_W(4), .CNT_W(2)) u16 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .in_valid(v16), .in_ready(irdy16),
    .in_a(a16), .in_b(b16), .in_mode(m16), .in_tag(t16),
    .out_valid(ov16), .out_ready(rdy16),
    .out_prod(p16), .out_mode(om16), .out_tag(ot16),
    .cnt_clr(clr16), .approx_cnt(cnt16)
  );

  // Exact: integer product. Approx: XOR of digit products per column.
  function automatic logic [31:0] ref_prod(input int w,
    input logic [15:0] a, input logic [15:0] b, input logic m);
    logic [31:0] r;
    logic [31:0] p;
    if (!m) begin
      r = {16'b0, a} * {16'b0, b};
    end else begin
      r = '0;
      for (int i = 0; i < w/4; i++) begin
        for (int j = 0; j < w/4; j++) begin
          p = 32'((a >> (4*i)) & 16'hF) * 32'((b >> (4*j)) & 16'hF);
          r = r ^ (p << (4*(i+j)));
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated 8-bit operation; checks latency, result, bubble.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
    input logic m, input logic [3:0] t, input logic [15:0] exp,
    input string nm);
    a8 = a; b8 = b; m8 = m; t8 = t; v8 = 1'b1; rdy8 = 1'b1;
    #1;
    chk({nm, "_in_ready"}, 32'(irdy8), 1);
    tick();
    v8 = 1'b0;
    if (m) cnt8m++;
    chk({nm, "_lat1"}, 32'(ov8), 0);
    tick();
    chk({nm, "_lat2"}, 32'(ov8), 0);
    tick();
    chk({nm, "_valid"}, 32'(ov8), 1);
    chk({nm, "_prod"}, 32'(p8), 32'(exp));
    chk({nm, "_mode"}, 32'(om8), 32'(m));
    chk({nm, "_tag"}, 32'(ot8), 32'(t));
    tick();
    chk({nm, "_bubble"}, 32'(ov8), 0);
    chk({nm, "_cnt"}, 32'(cnt8), 32'(cnt8m));
  endtask

  // One isolated 16-bit operation.
  task automatic op16(input logic [15:0] a, input logic [15:0] b,
    input logic m, input logic [3:0] t, input logic [31:0] exp,
    input string nm);
    a16 = a; b16 = b; m16 = m; t16 = t; v16 = 1'b1; rdy16 = 1'b1;
    tick();
    v16 = 1'b0;
    tick();
    chk({nm, "_lat2"}, 32'(ov16), 0);
    tick();
    chk({nm, "_valid"}, 32'(ov16), 1);
    chk({nm, "_prod"}, p16, exp);
    chk({nm, "_tag"}, 32'(ot16), 32'(t));
    tick();
  endtask

  // Back-to-back stream with optional stall after first out_valid.
  task automatic stream8(input int n, input int stall, input bit alt);
    logic [7:0]  sa[8];
    logic [7:0]  sb[8];
    logic        sm[8];
    logic [3:0]  st[8];
    logic [31:0] r;
    res8_t       e;
    int sent, got, left, cyc;
    bit seen, acc, hs;
    for (int k = 0; k < n; k++) begin
      sa[k] = 8'($urandom);
      sb[k] = 8'($urandom);
      sm[k] = alt ? 1'(k % 2) : 1'($urandom);
      st[k] = 4'(k + 3);
    end
    sent = 0; got = 0; left = stall; cyc = 0; seen = 0;
    while (got < n && cyc < 60) begin
      cyc++;
      v8 = (sent < n);
      if (sent < n) begin
        a8 = sa[sent]; b8 = sb[sent]; m8 = sm[sent]; t8 = st[sent];
      end
      rdy8 = !(seen && left > 0);
      #1;
      if (!rdy8) begin
        chk("bp_in_ready", 32'(irdy8), 0);
        chk("bp_valid", 32'(ov8), 1);
        if (q8.size() > 0) begin
          chk("bp_hold_prod", 32'(p8), 32'(q8[0].p));
          chk("bp_hold_tag", 32'(ot8), 32'(q8[0].t));
        end
        left--;
      end
      acc = v8 && irdy8;
      hs  = ov8 && rdy8;
      if (hs) begin
        if (q8.size() == 0) begin
          chk("stream_spurious", 1, 0);
        end else begin
          e = q8.pop_front();
          chk("stream_prod", 32'(p8), 32'(e.p));
          chk("stream_mode", 32'(om8), 32'(e.m));
          chk("stream_tag", 32'(ot8), 32'(e.t));
          got++;
        end
      end
      tick();
      if (acc) begin
        r = ref_prod(8, {8'b0, sa[sent]}, {8'b0, sb[sent]}, sm[sent]);
        e.p = r[15:0];
        e.m = sm[sent];
        e.t = st[sent];
        q8.push_back(e);
        if (sm[sent]) cnt8m++;
        sent++;
      end
      if (ov8) seen = 1;
    end
    v8 = 1'b0;
    rdy8 = 1'b1;
    chk("stream_count", 32'(got), 32'(n));
    chk("stream_cnt8", 32'(cnt8), 32'(cnt8m));
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rm;
    logic [31:0] r;
    checks = 0; failures = 0; cnt8m = 0;
    rst_n = 1'b0;
    v8 = 0; a8 = 0; b8 = 0; m8 = 0; t8 = 0; rdy8 = 1; clr8 = 0;
    v16 = 0; a16 = 0; b16 = 0; m16 = 0; t16 = 0; rdy16 = 1; clr16 = 0;
    #12;
    chk("rst_valid", 32'(ov8), 0);
    chk("rst_prod", 32'(p8), 0);
    chk("rst_mode", 32'(om8), 0);
    chk("rst_tag", 32'(ot8), 0);
    chk("rst_cnt", 32'(cnt8), 0);
    chk("rst_valid16", 32'(ov16), 0);
    tick();
    rst_n = 1'b1;
    tick();

    op8(8'h12, 8'h34, 1'b0, 4'h5, 16'h03A8, "ex_12x34");
    op8(8'hFF, 8'hFF, 1'b1, 4'h6, 16'hE1E1, "ap_FFxFF");
    op8(8'hFF, 8'hFF, 1'b0, 4'h7, 16'hFE01, "ex_FFxFF");
    op8(8'h12, 8'h34, 1'b1, 4'h8, 16'h0328, "ap_12x34");
    op8(8'h10, 8'h10, 1'b0, 4'h9, 16'h0100, "ex_10x10");
    op8(8'h10, 8'h10, 1'b1, 4'hA, 16'h0100, "ap_10x10");
    for (int k = 0; k < 4; k++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rm = 1'($urandom);
      r  = ref_prod(8, ra, rb, rm);
      op8(ra[7:0], rb[7:0], rm, 4'(k), r[15:0], "rnd8");
    end

    stream8(6, 0, 1'b1);
    stream8(5, 4, 1'b0);

    v8 = 1'b1; m8 = 1'b1; rdy8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); t8 = 4'(k);
      tick();
      cnt8m++;
    end
    chk("pre_rst_cnt", 32'(cnt8), 32'(cnt8m));
    rst_n = 1'b0;
    v8 = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov8), 0);
    chk("midrst_cnt", 32'(cnt8), 0);
    chk("midrst_prod", 32'(p8), 0);
    q8.delete();
    cnt8m = 0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_no_stale", 32'(ov8), 0);
    end

    op16(16'hFFFF, 16'hFFFF, 1'b0, 4'h1, 32'hFFFE0001, "ex16_max");
    for (int k = 1; k <= 5; k++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      op16(ra, rb, 1'b1, 4'(k), ref_prod(16, ra, rb, 1'b1), "ap16");
      chk("cnt16_sat", 32'(cnt16), 32'((k > 3) ? 3 : k));
    end
    a16 = 16'($urandom); b16 = 16'($urandom);
    v16 = 1'b1; m16 = 1'b1; clr16 = 1'b1;
    #1;
    chk("clr_in_ready", 32'(irdy16), 1);
    tick();
    v16 = 1'b0; clr16 = 1'b0;
    chk("clr_priority", 32'(cnt16), 0);
    repeat (3) tick();
    op16(16'h0F0F, 16'h00FF, 1'b1, 4'h2,
         ref_prod(16, 16'h0F0F, 16'h00FF, 1'b1), "ap16_after_clr");
    chk("cnt16_resume", 32'(cnt16), 1);
    for (int k = 0; k < 6; k++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      op16(ra, rb, 1'b0, 4'(k), {16'b0, ra} * {16'b0, rb}, "rnd16");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_nxn_pipe.md
Name: mult_nxn_pipe

Overview:
- Parametrised, pipelined successor of the 8x8 nibble-decomposed multiplier: unsigned WIDTH x WIDTH product built from 4x4 digit partial products.
- Per-transaction mode: exact (carry-propagating sum) or approximate (carry-free column XOR combining).
- Valid/ready streaming interface with full-pipe stall on backpressure, tag passthrough, and a saturating approximate-op counter.
- Sits between the feature-extraction datapath and the accumulator stage of the detector core.

Parameters:
- WIDTH, 8: operand width in bits; legal values 4, 8, 12, 16 (multiple of 4; other values are a configuration error).
- TAG_W, 4: width of the sideband tag carried alongside each operation.
- CNT_W, 16: width of the approximate-op counter.

Ports:
- sys_clk  in  1  clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an operation this cycle.
- in_a  in  WIDTH  multiplicand, unsigned.
- in_b  in  WIDTH  multiplier, unsigned.
- in_mode  in  1  0 = exact, 1 = approximate.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_prod  out  2*WIDTH  product.
- out_mode  out  1  mode the result was computed in.
- out_tag  out  TAG_W  tag of the result.
- cnt_clr  in  1  synchronous clear of approx_cnt.
- approx_cnt  out  CNT_W  number of accepted approximate operations, saturating.

Behaviour:
- Reset (async, sys_rst_n=0): all stage valids 0, out_valid=0, out_prod=0, out_mode=0, out_tag=0, approx_cnt=0. Reset mid-operation discards every in-flight operation with no output.
- Pipeline stages:
  - S1 registers a, b, mode and tag.
  - S2 registers all D*D 8-bit digit products p[i][j] = a_digit[i]*b_digit[j], where D = WIDTH/4 and digit k = bits [4k+3:4k]. Products are exact 4x4.
  - S3 combines the products and drives the output register.
- Latency is 3 cycles from the accepting edge to out_valid. Throughput is 1 operation per cycle.
- Combining: p[i][j] is placed at bit offset 4*(i+j).
  - Exact: out_prod = sum of all placed products, truncated to 2*WIDTH bits (never overflows).
  - Approximate: each out_prod bit is the XOR of every placed-product bit landing in that column; no carries anywhere.
  - For WIDTH=8 the approximate result is:
    - [3:0] = p00[3:0]
    - [7:4] = p00[7:4]^p10[3:0]^p01[3:0]
    - [11:8] = p10[7:4]^p01[7:4]^p11[3:0]
    - [15:12] = p11[7:4]
- Handshake:
  - Global enable en = !out_valid || out_ready, and in_ready = en.
  - An operation is accepted when in_valid && in_ready.
  - When en=0, every stage, including the output register, holds its value; out_prod, out_mode and out_tag stay stable while out_valid=1 && out_ready=0.
  - Bubbles advance as valid=0 when en=1.
  - in_* are don't-care when in_valid=0.
- approx_cnt:
  - Increments on each accepted operation with in_mode=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority: a clear and an acceptance in the same cycle give 0.
- Mode and tag travel with their own operation; a mode change between back-to-back operations takes effect per operation.

Test Plan:
- WIDTH=8, exact, A=0x12, B=0x34, out_ready=1 -> out_prod=0x03A8 exactly 3 cycles after acceptance, tag echoed.
- WIDTH=8, approx, A=0xFF, B=0xFF -> out_prod=0xE1E1; same operands exact -> 0xFE01; back-to-back alternating modes -> results in order with matching out_mode.
- WIDTH=8, approx, A=0x12, B=0x34 -> 0x0328; A=0x10, B=0x10 in both modes -> 0x0100.
- Backpressure: stream 5 operations, hold out_ready=0 for 4 cycles after first out_valid -> in_ready=0, outputs stable, then all 5 results in order with no loss or duplication.
- Reset mid-stream: assert sys_rst_n=0 with 3 operations in flight -> out_valid=0 immediately, approx_cnt=0, no stale result after release.
- WIDTH=16, CNT_W=2: exact 0xFFFF*0xFFFF -> 0xFFFE0001; 5 approximate acceptances -> approx_cnt=3; cnt_clr with a simultaneous approx acceptance -> 0; random exact operations match the reference product.
